// File: rtl/dadda_pkg.sv
// Shared types and constants for the Dadda product accumulator.
// ACC_W_DEF sizes the accumulator so ACC_LEN_MAX full-scale products cannot overflow.
package dadda_pkg;

  localparam int ACC_LEN_MAX = 16;
  localparam int PROD_W      = 8;
  localparam int CNT_W       = 5;
  localparam int ACC_W_DEF   = PROD_W + $clog2(ACC_LEN_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// Unsigned ripple-carry adder from full_adder cells, carry-in fixed at 0.
// The MSB has no carry-out: the accumulator width rules out overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module acc_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W - 1; i++) begin : gen_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign sum[W-1] = a[W-1] ^ b[W-1] ^ c[W-1];

endmodule

// File: rtl/dadda_prod_accum.sv
// Sums groups of up to ACC_LEN unsigned 4x4 products and presents each group
// total with its product count under a valid/ready handshake.
module dadda_prod_accum
  import dadda_pkg::*;
#(
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_sum,
  output logic [4:0]       out_cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             fire;
  logic             ofire;

  assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, in_prod};
  assign cnt_inc  = cnt + CNT_W'(1);

  acc_adder #(.W(ACC_W)) u_acc_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum)
  );

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign fire      = in_valid & in_ready;
  assign ofire     = out_valid & out_ready;
  assign out_sum   = out_valid ? acc : '0;
  assign out_cnt   = out_valid ? cnt : '0;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (fire) begin
          acc_nxt   = prod_ext;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (ACC_LEN == 1 || flush) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (fire) begin
          acc_nxt   = acc_sum;
          cnt_nxt   = cnt_inc;
          state_nxt = (cnt_inc == LEN_C || flush) ? HOLD : ACC;
        end else if (flush) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ofire) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
